// File: rtl/running_subtractor.sv
// Running subtractor: loads a starting value, then subtracts a stream of unsigned
// operands. On the first borrow the value saturates to zero and the block halts until reloaded.
module running_subtractor #(
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ACC_WIDTH-1:0] load_value,
    input  logic                 op_valid,
    input  logic [OP_WIDTH-1:0]  new_operand,
    output logic                 op_ready,
    output logic [ACC_WIDTH-1:0] current_value,
    output logic                 underflow,
    output logic                 zero,
    output logic [7:0]           op_count
);

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        HALTED
    } state_t;

    state_t             state;
    logic               accept;
    logic [ACC_WIDTH:0] diff;

    assign op_ready = (state == ACTIVE) && !load;
    assign accept   = op_valid && op_ready;
    assign zero     = (state == ACTIVE) && (current_value == '0);

    // The extra top bit of diff is the borrow out of the subtraction.
    assign diff = {1'b0, current_value} - {{(ACC_WIDTH + 1 - OP_WIDTH){1'b0}}, new_operand};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= EMPTY;
            current_value <= '0;
            underflow     <= 1'b0;
            op_count      <= '0;
        end else if (load) begin
            state         <= ACTIVE;
            current_value <= load_value;
            underflow     <= 1'b0;
            op_count      <= '0;
        end else if (accept) begin
            if (op_count != 8'hff) begin
                op_count <= op_count + 8'd1;
            end
            if (diff[ACC_WIDTH]) begin
                current_value <= '0;
                underflow     <= 1'b1;
                state         <= HALTED;
            end else begin
                current_value <= diff[ACC_WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/running_subtractor.md
RUNNING_SUBTRACTOR -- requirements
Module: running_subtractor

Interface
REQ-001 Parameter OP_WIDTH, default 8, SHALL set the operand width in bits.
REQ-002 Parameter ACC_WIDTH, default 16, SHALL set the accumulator width in bits; ACC_WIDTH > OP_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 load  input  1  SHALL request a load of load_value into the accumulator.
REQ-006 load_value  input  ACC_WIDTH  SHALL be the starting value, sampled when load=1.
REQ-007 op_valid  input  1  SHALL indicate that new_operand holds an operand to subtract.
REQ-008 new_operand  input  OP_WIDTH  SHALL be the unsigned operand to subtract.
REQ-009 op_ready  output  1  SHALL indicate that the block accepts an operand this cycle.
REQ-010 current_value  output  ACC_WIDTH  SHALL be the registered accumulator value.
REQ-011 underflow  output  1  SHALL be a registered, sticky borrow-out flag.
REQ-012 zero  output  1  SHALL be 1 when state is ACTIVE and current_value == 0.
REQ-013 op_count  output  8  SHALL be the registered count of operands accepted since the last load.

Function
REQ-014 The state machine SHALL have three states: EMPTY, ACTIVE and HALTED.
REQ-015 op_ready SHALL be combinational and equal (state == ACTIVE) && !load.
REQ-016 An operand SHALL be accepted only in a cycle where op_valid && op_ready; op_valid while op_ready=0 SHALL be ignored with no side effects.
REQ-017 load=1 in any state SHALL, at the next edge, set current_value=load_value, op_count=0, underflow=0 and state=ACTIVE.
REQ-018 load SHALL take priority over a same-cycle op_valid; that operand is not accepted, and the source must hold it.
REQ-019 On acceptance, the block SHALL compute diff = {1'b0,current_value} - zero-extended new_operand at ACC_WIDTH+1 bits.
REQ-020 If diff has no borrow (MSB 0), the block SHALL set current_value=diff[ACC_WIDTH-1:0] at the next edge and stay in ACTIVE.
REQ-021 If diff borrows (MSB 1), the block SHALL at the next edge set current_value=0 (saturate), underflow=1 and state=HALTED.
REQ-022 Latency SHALL be one cycle: the result of an accepted operand appears on current_value/underflow/op_count at the edge ending the acceptance cycle.
REQ-023 One operand SHALL be accepted per cycle, with back-to-back acceptances producing consecutive results.
REQ-024 op_count SHALL increment on every acceptance, including the underflowing one and zero-valued operands, and SHALL saturate at 255.
REQ-025 An operand equal to current_value SHALL produce 0 with no underflow and zero=1; the state SHALL remain ACTIVE.
REQ-026 In ACTIVE with current_value=0, a nonzero operand SHALL underflow, and an operand of 0 SHALL be accepted with no change other than op_count.
REQ-027 In HALTED and EMPTY, the only exits SHALL be load or reset; current_value, underflow and op_count SHALL hold.
REQ-028 The block SHALL never change current_value while op_valid is asserted and no operand is accepted.

Reset
REQ-029 reset=1 at a rising edge SHALL force state=EMPTY, current_value=0, underflow=0 and op_count=0; consequently op_ready=0 and zero=0.
REQ-030 reset SHALL take priority over load and op_valid in the same cycle.
REQ-031 Reset asserted mid-sequence SHALL discard any operand presented in that cycle.

Verification
REQ-032 reset, then load 16'hff00, then one operand 8'hff -> current_value=16'hfe01, underflow=0, op_count=1 one cycle after acceptance.
REQ-033 load 16'h4242, then operands 8'h42 and 8'h20 back-to-back -> 16'h4200, then 16'h41e0, op_count=2, op_ready held high throughout.
REQ-034 load 16'h0010, then operand 8'h10 -> current_value=0, zero=1, state ACTIVE; then 8'h01 -> underflow=1, current_value=0, op_ready=0; further op_valid is ignored.
REQ-035 load=1 and op_valid=1 with 8'h05 in the same cycle, with load_value=16'h0100 -> current_value=16'h0100, op_count=0; the held operand is accepted next cycle -> 16'h00fb.
REQ-036 op_valid pulsed while in EMPTY after reset -> no change to any output; 300 zero operands after load -> op_count=255, current_value unchanged.
REQ-037 reset asserted the same cycle as an accepted operand while in ACTIVE -> all outputs at reset values next cycle.
